// File: rtl/sw_pkg.sv
// Shared types and constants for the stopwatch time counter.
package sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam int CS_WRAP  = 99;
  localparam int SEC_WRAP = 59;

  // Converts 0..99 into two packed BCD digits, tens in the upper nibble.
  function automatic logic [7:0] to_bcd2(input int v);
    bcd_t tens;
    bcd_t ones;
    tens = bcd_t'(v / 10);
    ones = bcd_t'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD modulo counter; carry flags the terminal value so the
// parent can ripple enables without a combinational loop.
module bcd2_counter
  import sw_pkg::*;
#(
  parameter int WRAP = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry
);

  localparam logic [7:0] WRAP_BCD = to_bcd2(WRAP);

  bcd_t tens_r;
  bcd_t ones_r;
  bcd_t tens_s;
  bcd_t ones_s;

  assign value = {tens_r, ones_r};
  assign carry = (value == WRAP_BCD);

  // Next digit values: clear wins, then increment with wrap.
  always_comb begin
    tens_s = tens_r;
    ones_s = ones_r;
    if (clr) begin
      tens_s = 4'd0;
      ones_s = 4'd0;
    end else if (inc) begin
      if (carry) begin
        tens_s = 4'd0;
        ones_s = 4'd0;
      end else if (ones_r == 4'd9) begin
        tens_s = tens_r + 4'd1;
        ones_s = 4'd0;
      end else begin
        ones_s = ones_r + 4'd1;
      end
    end else begin
      tens_s = tens_r;
      ones_s = ones_r;
    end
  end

  // Digit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_r <= 4'd0;
      ones_r <= 4'd0;
    end else begin
      tens_r <= tens_s;
      ones_r <= ones_s;
    end
  end

endmodule

// File: rtl/sw_time_counter.sv
// Stopwatch mm:ss.cc counter driven by the 10 ms base tick.
// Optional lap-hold display freeze is built only when SW_LAP_HOLD_EN is defined.
module sw_time_counter
  import sw_pkg::*;
#(
  parameter int MAX_MINUTES = 59
) (
  input  logic       i_sclk,
  input  logic       i_reset_n,
  input  logic       i_basetick,
  input  logic       i_startstop,
  input  logic       i_clear,
  input  logic       i_lap,
  output logic       o_timerenb,
  output logic [7:0] o_cs,
  output logic [7:0] o_sec,
  output logic [7:0] o_min,
  output logic       o_overflow,
  output logic       o_lap_active
);

  sw_state_t  state_r;
  sw_state_t  state_s;
  logic       base_d_r;
  logic       armed_r;
  logic       tick_r;
  logic       timerenb_r;
  logic       overflow_r;
  logic       tick_det_s;
  logic       tick_en_s;
  logic       at_max_s;
  logic       ovf_hit_s;
  logic       cs_inc_s;
  logic       sec_inc_s;
  logic       min_inc_s;
  logic       cs_carry_s;
  logic       sec_carry_s;
  logic       min_carry_s;
  logic [7:0] cs_s;
  logic [7:0] sec_s;
  logic [7:0] min_s;

  // armed_r masks the first cycle after reset so a high basetick is not an edge.
  assign tick_det_s = armed_r & i_basetick & ~base_d_r;
  assign tick_en_s  = tick_r & (state_r == ST_RUN) & ~i_clear;
  assign at_max_s   = cs_carry_s & sec_carry_s & min_carry_s;
  assign ovf_hit_s  = tick_en_s & at_max_s;
  assign cs_inc_s   = tick_en_s & ~at_max_s;
  assign sec_inc_s  = cs_inc_s & cs_carry_s;
  assign min_inc_s  = sec_inc_s & sec_carry_s;

  bcd2_counter #(.WRAP(CS_WRAP)) u_cs (
    .clk(i_sclk), .rst_n(i_reset_n), .inc(cs_inc_s), .clr(i_clear),
    .value(cs_s), .carry(cs_carry_s)
  );

  bcd2_counter #(.WRAP(SEC_WRAP)) u_sec (
    .clk(i_sclk), .rst_n(i_reset_n), .inc(sec_inc_s), .clr(i_clear),
    .value(sec_s), .carry(sec_carry_s)
  );

  bcd2_counter #(.WRAP(MAX_MINUTES)) u_min (
    .clk(i_sclk), .rst_n(i_reset_n), .inc(min_inc_s), .clr(i_clear),
    .value(min_s), .carry(min_carry_s)
  );

  // Edge detector and one-cycle tick pipeline.
  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      base_d_r <= 1'b0;
      armed_r  <= 1'b0;
      tick_r   <= 1'b0;
    end else begin
      base_d_r <= i_basetick;
      armed_r  <= 1'b1;
      tick_r   <= tick_det_s & (state_r == ST_RUN) & ~i_clear;
    end
  end

  // Next state: clear, then saturation, then start/stop (locked out on overflow).
  always_comb begin
    state_s = state_r;
    if (i_clear) begin
      state_s = ST_IDLE;
    end else if (ovf_hit_s) begin
      state_s = ST_PAUSE;
    end else if (i_startstop && !overflow_r) begin
      case (state_r)
        ST_IDLE:  state_s = ST_RUN;
        ST_RUN:   state_s = ST_PAUSE;
        ST_PAUSE: state_s = ST_RUN;
        default:  state_s = ST_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, timer enable and sticky overflow registers.
  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r    <= ST_IDLE;
      timerenb_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      timerenb_r <= (state_s == ST_RUN);
      overflow_r <= i_clear ? 1'b0 : (overflow_r | ovf_hit_s);
    end
  end

  assign o_timerenb = timerenb_r;
  assign o_overflow = overflow_r;

`ifdef SW_LAP_HOLD_EN
  logic       lap_r;
  logic [7:0] lap_cs_r;
  logic [7:0] lap_sec_r;
  logic [7:0] lap_min_r;

  // Lap snapshot: armed only from RUN, released by a second lap or clear.
  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lap_r     <= 1'b0;
      lap_cs_r  <= 8'h00;
      lap_sec_r <= 8'h00;
      lap_min_r <= 8'h00;
    end else if (i_clear) begin
      lap_r <= 1'b0;
    end else if (i_lap && lap_r) begin
      lap_r <= 1'b0;
    end else if (i_lap && (state_r == ST_RUN)) begin
      lap_r     <= 1'b1;
      lap_cs_r  <= cs_s;
      lap_sec_r <= sec_s;
      lap_min_r <= min_s;
    end else begin
      lap_r <= lap_r;
    end
  end

  assign o_lap_active = lap_r;
  assign o_cs         = lap_r ? lap_cs_r  : cs_s;
  assign o_sec        = lap_r ? lap_sec_r : sec_s;
  assign o_min        = lap_r ? lap_min_r : min_s;
`else
  logic unused_lap_s;
  assign unused_lap_s = i_lap;
  assign o_lap_active = 1'b0;
  assign o_cs         = cs_s;
  assign o_sec        = sec_s;
  assign o_min        = min_s;
`endif

endmodule

// File: tb/tb_sw_time_counter.sv
// Directed, table-driven bench for sw_time_counter (default and MAX_MINUTES=1 instances).
module tb_sw_time_counter;

  logic clk;
  logic rst_n;
  logic a_base, a_ss, a_clr, a_lap;
  logic b_base, b_ss, b_clr, b_lap;
  logic a_enb, a_ovf, a_lapact, b_enb, b_ovf, b_lapact;
  logic [7:0] a_cs, a_sec, a_min, b_cs, b_sec, b_min;

  int total = 0;
  int bad   = 0;

  sw_time_counter dut (
    .i_sclk(clk), .i_reset_n(rst_n), .i_basetick(a_base), .i_startstop(a_ss),
    .i_clear(a_clr), .i_lap(a_lap), .o_timerenb(a_enb), .o_cs(a_cs), .o_sec(a_sec),
    .o_min(a_min), .o_overflow(a_ovf), .o_lap_active(a_lapact)
  );

  sw_time_counter #(.MAX_MINUTES(1)) dut1 (
    .i_sclk(clk), .i_reset_n(rst_n), .i_basetick(b_base), .i_startstop(b_ss),
    .i_clear(b_clr), .i_lap(b_lap), .o_timerenb(b_enb), .o_cs(b_cs), .o_sec(b_sec),
    .o_min(b_min), .o_overflow(b_ovf), .o_lap_active(b_lapact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ss;
    logic        clr;
    int          ticks;
    logic [23:0] t;   // {min, sec, cs}
    logic [2:0]  f;   // {timerenb, overflow, lap_active}
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string name, input logic [23:0] t, input logic [2:0] f);
    chk({name, "_time"}, {8'h00, a_min, a_sec, a_cs}, {8'h00, t});
    chk({name, "_flags"}, {29'd0, a_enb, a_ovf, a_lapact}, {29'd0, f});
  endtask

  task automatic chk_b(input string name, input logic [23:0] t, input logic [2:0] f);
    chk({name, "_time"}, {8'h00, b_min, b_sec, b_cs}, {8'h00, t});
    chk({name, "_flags"}, {29'd0, b_enb, b_ovf, b_lapact}, {29'd0, f});
  endtask

  task automatic tick_n(input bit on_b, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (on_b) b_base = 1'b1; else a_base = 1'b1;
      @(posedge clk); #1;
      a_base = 1'b0;
      b_base = 1'b0;
    end
  endtask

  task automatic pulse(input bit on_b, input logic ss, input logic clr, input logic lap);
    @(posedge clk); #1;
    if (on_b) begin b_ss = ss; b_clr = clr; b_lap = lap; end
    else begin a_ss = ss; a_clr = clr; a_lap = lap; end
    @(posedge clk); #1;
    a_ss = 1'b0; a_clr = 1'b0; a_lap = 1'b0;
    b_ss = 1'b0; b_clr = 1'b0; b_lap = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b1;
    {a_base, a_ss, a_clr, a_lap} = 4'b0000;
    {b_base, b_ss, b_clr, b_lap} = 4'b0000;

    //            ss    clr   ticks  {min,sec,cs}  {enb,ovf,lap}
    vecs[0] = '{1'b0, 1'b0,    5, 24'h000000, 3'b000};  // idle discards ticks
    vecs[1] = '{1'b1, 1'b0,  150, 24'h000150, 3'b100};  // 150 ticks -> 01.50
    vecs[2] = '{1'b1, 1'b0,    7, 24'h000150, 3'b000};  // pause discards
    vecs[3] = '{1'b1, 1'b0,   49, 24'h000199, 3'b100};  // resume
    vecs[4] = '{1'b0, 1'b0,    1, 24'h000200, 3'b100};  // cs 99 -> 00 carry
    vecs[5] = '{1'b0, 1'b1,    0, 24'h000000, 3'b000};  // clear from run
    vecs[6] = '{1'b0, 1'b0,    3, 24'h000000, 3'b000};
    vecs[7] = '{1'b1, 1'b0, 1234, 24'h001234, 3'b100};
    vecs[8] = '{1'b0, 1'b1,    0, 24'h000000, 3'b000};

    #2 rst_n = 1'b0;
    #6;
    chk_a("reset", 24'h000000, 3'b000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_a("post_release", 24'h000000, 3'b000);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].ss) pulse(1'b0, 1'b1, 1'b0, 1'b0);
      if (vecs[i].clr) pulse(1'b0, 1'b0, 1'b1, 1'b0);
      tick_n(1'b0, vecs[i].ticks);
      settle();
      chk_a($sformatf("vec%0d", i), vecs[i].t, vecs[i].f);
    end

    // 00:59.99 then one tick: unchanged on the detect edge, rolled over one edge later
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    tick_n(1'b0, 5999);
    settle();
    chk_a("preload", 24'h005999, 3'b100);
    @(posedge clk); #1 a_base = 1'b1;
    @(posedge clk); #1 a_base = 1'b0;
    @(negedge clk);
    chk_a("detect_edge", 24'h005999, 3'b100);
    @(negedge clk);
    chk_a("min_carry", 24'h010000, 3'b100);

    // clear + startstop + tick in one cycle
    @(posedge clk); #1 {a_base, a_ss, a_clr} = 3'b111;
    @(posedge clk); #1 {a_base, a_ss, a_clr} = 3'b000;
    @(negedge clk);
    chk_a("same_cycle", 24'h000000, 3'b000);
    @(negedge clk);
    chk_a("same_cycle_after", 24'h000000, 3'b000);

`ifdef SW_LAP_HOLD_EN
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    tick_n(1'b0, 20);
    settle();
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_a("lap_on", 24'h000020, 3'b101);
    tick_n(1'b0, 30);
    settle();
    chk_a("lap_frozen", 24'h000020, 3'b101);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_a("lap_off", 24'h000050, 3'b100);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_a("lap_in_pause", 24'h000050, 3'b000);
`else
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    tick_n(1'b0, 20);
    settle();
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    tick_n(1'b0, 5);
    settle();
    chk_a("lap_ignored", 24'h000025, 3'b100);
`endif

    // asynchronous reset in the middle of a run
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    tick_n(1'b0, 1234);
    settle();
    chk_a("pre_reset", 24'h001234, 3'b100);
    #2 rst_n = 1'b0;
    #1;
    chk_a("async_reset", 24'h000000, 3'b000);
    a_base = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_a("release_high_base", 24'h000000, 3'b000);
    a_base = 1'b0;

    // saturation on the MAX_MINUTES=1 instance
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    tick_n(1'b1, 11999);
    settle();
    chk_b("at_max", 24'h015999, 3'b100);
    tick_n(1'b1, 1);
    settle();
    chk_b("overflow", 24'h015999, 3'b010);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    tick_n(1'b1, 3);
    settle();
    chk_b("ovf_startstop", 24'h015999, 3'b010);
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk_b("ovf_clear", 24'h000000, 3'b000);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    tick_n(1'b1, 1);
    settle();
    chk_b("restart", 24'h000001, 3'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_time_counter.md
SW_TIME_COUNTER -- requirements
Module: sw_time_counter

Interface
REQ-001 SHALL have parameter MAX_MINUTES, default 59, meaning the highest minute value (BCD-displayable, 0..99).
REQ-002 SHALL have port i_sclk, input, 1 bit: 100 MHz system clock; all logic on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port i_basetick, input, 1 bit: 100 Hz square wave from the upstream 10 ms timer; each rising edge is one 10 ms tick.
REQ-005 SHALL have port i_startstop, input, 1 bit: one-cycle pulse that toggles run/pause.
REQ-006 SHALL have port i_clear, input, 1 bit: one-cycle pulse that zeroes the time and returns to idle.
REQ-007 SHALL have port i_lap, input, 1 bit: one-cycle pulse that toggles the lap hold (used only per REQ-024).
REQ-008 SHALL have port o_timerenb, output, 1 bit: enable to the upstream timer.
REQ-009 SHALL have ports o_cs, o_sec and o_min, outputs, 8 bits each: displayed time as two BCD digits, tens in [7:4].
REQ-010 SHALL have port o_overflow, output, 1 bit: sticky saturation flag.
REQ-011 SHALL have port o_lap_active, output, 1 bit: high while the display is frozen.

Function
REQ-012 SHALL detect a tick as i_basetick=1 in the current cycle and 0 in the previous cycle, using one register.
REQ-013 SHALL update the count on the clock edge after the one where the tick is detected (1-cycle latency); one tick adds exactly one centisecond.
REQ-014 SHALL implement states IDLE, RUN and PAUSE:
- IDLE + startstop -> RUN
- RUN + startstop -> PAUSE
- PAUSE + startstop -> RUN
- any state + clear -> IDLE
REQ-015 SHALL give i_clear priority over i_startstop and over a tick in the same cycle; clear zeroes the count and clears o_overflow.
REQ-016 SHALL count ticks only in RUN; ticks in IDLE and PAUSE are discarded.
REQ-017 SHALL drive o_timerenb=1 exactly when the state is RUN, registered.
REQ-018 SHALL wrap and carry:
- cs 99 -> 00, carry into sec
- sec 59 -> 00, carry into min
- every digit is always valid BCD (0..9)
REQ-019 SHALL, on a tick at MAX_MINUTES:59.99, hold the count at MAX_MINUTES:59.99, set o_overflow and move to PAUSE.
REQ-020 SHALL ignore i_startstop while o_overflow=1.

Reset
REQ-021 SHALL, on i_reset_n low at any time, immediately force: state IDLE; count 00:00.00; o_timerenb=0; o_overflow=0; o_lap_active=0; edge register 0.
REQ-022 SHALL hold the reset state while i_reset_n=0, and SHALL NOT detect a tick in the first cycle after release even if i_basetick=1.

Configuration
REQ-023 SHALL compile the lap-hold feature only when the macro SW_LAP_HOLD_EN is defined.
REQ-024 SHALL, with SW_LAP_HOLD_EN defined:
- i_lap in RUN with no hold active: capture the count, freeze the outputs, set o_lap_active; counting continues internally
- i_lap while a hold is active, or i_clear: release the hold
- i_lap in IDLE or PAUSE with no hold active: ignored
REQ-025 SHALL, without SW_LAP_HOLD_EN: ignore i_lap, tie o_lap_active to 0 and show the live count on the outputs.

Structure
REQ-026 SHALL place in shared package sw_pkg: the state enum typedef, a 4-bit BCD digit typedef, and constants CS_WRAP=99 and SEC_WRAP=59.
REQ-027 SHALL use sub-module bcd2_counter (two-digit BCD modulo counter with parameter wrap value, inputs inc and clr, output carry), instantiated three times (cs, sec, min).

Verification
REQ-028 SHALL cover: reset, startstop, 150 basetick rising edges -> o_cs=8'h50, o_sec=8'h01, o_min=8'h00; o_timerenb=1.
REQ-029 SHALL cover: preload 00:59.99, one tick -> 01:00.00 on the next cycle.
REQ-030 SHALL cover: MAX_MINUTES=1, run to 01:59.99, one tick -> count holds, o_overflow=1, state PAUSE, o_timerenb=0; then startstop -> no change; then clear -> 00:00.00, o_overflow=0.
REQ-031 SHALL cover: clear, startstop and a tick all in the same cycle -> IDLE, 00:00.00, o_timerenb=0.
REQ-032 SHALL cover: reset asserted mid-RUN at 00:12.34 -> outputs zero in the same cycle, independent of i_sclk.
REQ-033 SHALL cover (with SW_LAP_HOLD_EN): lap at 00:00.20, 30 more ticks -> outputs stay 8'h20, 8'h00, 8'h00; second lap -> outputs show 00:00.50.
